udp_tx_axis_frame_arbiter: RTL and testbench

- Frame-level round-robin arbiter sharing the single XDMA-side AXI-Stream ingress of the UDP/IP/ARP/Ethernet/CMAC TX path between NUM_SRC independent requesters, for example multiple DMA channels or an on-chip packet generator.
- Sits in the udp_clk domain directly in front of the wrapper's xdma_rx_axis_* input.
- A grant is locked for a whole frame so beats of different frames never interleave.
- Exposes grant and frame-count status for debug and test.

---
 rtl/udp_tx_axis_frame_arbiter_if.sv | 17 +
 rtl/udp_tx_axis_frame_arbiter.sv | 73 +++++++
 tb/tb_udp_tx_axis_frame_arbiter.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/udp_tx_axis_frame_arbiter_if.sv
// udp_tx_axis_frame_arbiter_if: N-lane AXI-Stream bundle; lane i owns slice i of every vector field
`timescale 1ns/1ps
interface udp_tx_axis_frame_arbiter_if #(
    parameter int N   = 1,
    parameter int TDW = 512,
    parameter int TKW = 64,
    parameter int TUW = 1
);
    logic [N-1:0]     tvalid;
    logic [N-1:0]     tready;
    logic [N-1:0]     tlast;
    logic [N*TDW-1:0] tdata;
    logic [N*TKW-1:0] tkeep;
    logic [N*TUW-1:0] tuser;
    modport master(output tvalid, tlast, tdata, tkeep, tuser, input tready);
    modport slave(input tvalid, tlast, tdata, tkeep, tuser, output tready);
endinterface

// File: rtl/udp_tx_axis_frame_arbiter.sv
// udp_tx_axis_frame_arbiter: frame-locked round-robin mux of NUM_SRC AXIS sources onto one AXIS egress
`timescale 1ns/1ps
module udp_tx_axis_frame_arbiter #(
    parameter int NUM_SRC       = 2,
    parameter int SRC_IDX_WIDTH = 1,
    parameter int TDATA_WIDTH   = 512,
    parameter int TKEEP_WIDTH   = 64,
    parameter int TUSER_WIDTH   = 1,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                               udp_clk,
    input  logic                               udp_reset,
    udp_tx_axis_frame_arbiter_if.slave         s_axis,
    udp_tx_axis_frame_arbiter_if.master        m_axis,
    output logic                               grant_valid,
    output logic [SRC_IDX_WIDTH-1:0]           grant_idx,
    output logic [CNT_WIDTH-1:0]               frame_cnt
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t                   state_q, state_d;
    logic [SRC_IDX_WIDTH-1:0] grant_q, grant_d;
    logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;
    logic [SRC_IDX_WIDTH-1:0] winner, cand;
    logic                     found, hs;
    // scan farthest-to-nearest so the source closest after the pointer wins
    always_comb begin
        found  = 1'b0;
        winner = grant_q;
        cand   = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            cand = SRC_IDX_WIDTH'((int'(grant_q) + k) % NUM_SRC);
            if (s_axis.tvalid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end
    always_comb begin
        m_axis.tvalid = state_q == BUSY && s_axis.tvalid[grant_q];
        m_axis.tlast  = s_axis.tlast[grant_q];
        m_axis.tdata  = s_axis.tdata[int'(grant_q)*TDATA_WIDTH +: TDATA_WIDTH];
        m_axis.tkeep  = s_axis.tkeep[int'(grant_q)*TKEEP_WIDTH +: TKEEP_WIDTH];
        m_axis.tuser  = s_axis.tuser[int'(grant_q)*TUSER_WIDTH +: TUSER_WIDTH];
        s_axis.tready = state_q == BUSY ? NUM_SRC'(m_axis.tready) << grant_q : '0;
    end
    assign hs = m_axis.tvalid[0] && m_axis.tready[0];
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE) begin
            state_d = found ? BUSY : IDLE;
            grant_d = found ? winner : grant_q;
        end else if (hs && m_axis.tlast[0]) begin
            state_d = IDLE;
            cnt_d   = cnt_q + CNT_WIDTH'(1);
        end
    end
    always_ff @(posedge udp_clk) begin
        if (udp_reset) begin
            state_q <= IDLE;
            grant_q <= SRC_IDX_WIDTH'(NUM_SRC - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
        end
    end
    assign grant_valid = state_q == BUSY;
    assign grant_idx   = grant_q;
    assign frame_cnt   = cnt_q;
endmodule

// File: tb/tb_udp_tx_axis_frame_arbiter.sv
// tb_udp_tx_axis_frame_arbiter: queue-driven source BFMs with an in-order egress scoreboard
`timescale 1ns/1ps
module tb_udp_tx_axis_frame_arbiter;
    localparam int NS = 2, TDW = 512, TKW = 64, TUW = 1;
    typedef struct packed {logic [31:0] d; logic l;} beat_t;
    typedef struct packed {logic [3:0] src; logic [31:0] d; logic l;} exp_t;
    logic udp_clk = 1'b0;
    logic udp_reset = 1'b1;
    always #5 udp_clk = ~udp_clk;
    udp_tx_axis_frame_arbiter_if #(.N(NS), .TDW(TDW), .TKW(TKW), .TUW(TUW)) s_if();
    udp_tx_axis_frame_arbiter_if #(.N(1), .TDW(TDW), .TKW(TKW), .TUW(TUW)) m_if();
    udp_tx_axis_frame_arbiter_if #(.N(NS), .TDW(TDW), .TKW(TKW), .TUW(TUW)) w_s();
    udp_tx_axis_frame_arbiter_if #(.N(1), .TDW(TDW), .TKW(TKW), .TUW(TUW)) w_m();
    logic        gv, wgv;
    logic [0:0]  gi, wgi;
    logic [31:0] fc;
    logic [3:0]  wfc;
    udp_tx_axis_frame_arbiter #(.NUM_SRC(NS), .SRC_IDX_WIDTH(1), .TDATA_WIDTH(TDW), .TKEEP_WIDTH(TKW),
        .TUSER_WIDTH(TUW), .CNT_WIDTH(32)) dut (
        .udp_clk(udp_clk), .udp_reset(udp_reset), .s_axis(s_if), .m_axis(m_if),
        .grant_valid(gv), .grant_idx(gi), .frame_cnt(fc));
    udp_tx_axis_frame_arbiter #(.NUM_SRC(NS), .SRC_IDX_WIDTH(1), .TDATA_WIDTH(TDW), .TKEEP_WIDTH(TKW),
        .TUSER_WIDTH(TUW), .CNT_WIDTH(4)) dut_wrap (
        .udp_clk(udp_clk), .udp_reset(udp_reset), .s_axis(w_s), .m_axis(w_m),
        .grant_valid(wgv), .grant_idx(wgi), .frame_cnt(wfc));

    beat_t src_q[NS][$];
    exp_t  exp_q[$];
    int    tests = 0, fails = 0, beats = 0;
    logic [NS-1:0] hs;

    function automatic logic [TKW-1:0] keep_of(input logic [31:0] d);
        return {d, ~d};
    endfunction

    task automatic add_frame(input int src, input logic [31:0] base, input int n, input int n_exp);
        beat_t b;
        exp_t  e;
        for (int k = 0; k < n; k++) begin
            b.d = base + 32'(k);
            b.l = (k == n - 1);
            src_q[src].push_back(b);
            if (k < n_exp) begin
                e.src = 4'(src);
                e.d   = b.d;
                e.l   = b.l;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || src_q[0].size() != 0 || src_q[1].size() != 0) && n < budget) begin
            @(posedge udp_clk);
            #2;
            n++;
        end
        tests++;
        if (exp_q.size() != 0 || src_q[0].size() != 0 || src_q[1].size() != 0) begin
            fails++;
            $display("FAIL %s_drain: %0d beats outstanding, required 0", name, exp_q.size());
        end
    endtask

    task automatic pulse_reset;
        @(negedge udp_clk);
        udp_reset = 1'b1;
        @(posedge udp_clk);
        #2 udp_reset = 1'b0;
    endtask

    initial begin
        s_if.tvalid = '0; s_if.tlast = '0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tuser = '0;
        forever begin
            @(negedge udp_clk);
            hs = s_if.tvalid & s_if.tready;
            @(posedge udp_clk);
            #1;
            for (int i = 0; i < NS; i++) begin
                if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                if (src_q[i].size() > 0) begin
                    s_if.tvalid[i]              = 1'b1;
                    s_if.tlast[i]               = src_q[i][0].l;
                    s_if.tdata[i*TDW +: TDW]    = TDW'(src_q[i][0].d);
                    s_if.tkeep[i*TKW +: TKW]    = keep_of(src_q[i][0].d);
                    s_if.tuser[i]               = src_q[i][0].d[0];
                end else begin
                    s_if.tvalid[i] = 1'b0;
                    s_if.tlast[i]  = 1'b0;
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge udp_clk);
            if (m_if.tvalid[0] && m_if.tready[0]) begin
                beats++;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL beat_unexpected: got data=%0h src=%0d, required no beat", m_if.tdata[31:0], gi);
                end else begin
                    e = exp_q.pop_front();
                    if (m_if.tdata !== TDW'(e.d) || m_if.tkeep !== keep_of(e.d) || m_if.tuser[0] !== e.d[0]
                        || m_if.tlast[0] !== e.l || gi !== e.src[0]) begin
                        fails++;
                        $display("FAIL beat: got data=%0h last=%0b src=%0d, required data=%0h last=%0b src=%0d",
                            m_if.tdata[31:0], m_if.tlast[0], gi, e.d, e.l, e.src);
                    end
                end
            end
        end
    end

    task automatic test_reset;
        m_if.tready = 1'b1;
        repeat (3) @(posedge udp_clk);
        #2 udp_reset = 1'b0;
        @(negedge udp_clk);
        tests++; if (gv !== 1'b0) begin fails++; $display("FAIL rst_grant_valid: got %0b required 0", gv); end
        tests++; if (gi !== 1'b1) begin fails++; $display("FAIL rst_grant_idx: got %0d required 1", gi); end
        tests++; if (fc !== 32'd0) begin fails++; $display("FAIL rst_frame_cnt: got %0d required 0", fc); end
        tests++; if (m_if.tvalid !== 1'b0 || s_if.tready !== 2'b00) begin
            fails++; $display("FAIL rst_valid_ready: got tvalid=%0b tready=%b required 0/00", m_if.tvalid, s_if.tready);
        end
    endtask

    task automatic test_single_frame;
        add_frame(0, 32'hA0, 3, 3);
        @(posedge udp_clk);
        @(negedge udp_clk);
        tests++; if (m_if.tvalid !== 1'b0) begin fails++; $display("FAIL arb_cycle: got tvalid=%0b required 0", m_if.tvalid); end
        @(negedge udp_clk);
        tests++; if (m_if.tvalid !== 1'b1 || m_if.tdata[31:0] !== 32'hA0 || gv !== 1'b1 || gi !== 1'b0) begin
            fails++; $display("FAIL first_beat: got tvalid=%0b data=%0h gv=%0b gi=%0d required 1/a0/1/0",
                m_if.tvalid, m_if.tdata[31:0], gv, gi);
        end
        drain("single", 20);
        tests++; if (fc !== 32'd1 || gv !== 1'b0 || gi !== 1'b0) begin
            fails++; $display("FAIL single_end: got cnt=%0d gv=%0b gi=%0d required 1/0/0", fc, gv, gi);
        end
    endtask

    task automatic test_round_robin;
        logic [11:0] pat;
        pulse_reset();
        @(negedge udp_clk);
        add_frame(0, 32'h100, 2, 2);
        add_frame(1, 32'h200, 2, 2);
        add_frame(0, 32'h110, 2, 2);
        add_frame(1, 32'h210, 2, 2);
        @(posedge udp_clk);
        for (int k = 0; k < 12; k++) begin
            @(negedge udp_clk);
            pat[k] = m_if.tvalid[0] && m_if.tready[0];
        end
        tests++; if (pat !== 12'b110110110110) begin fails++; $display("FAIL rr_bubbles: got %b required 110110110110", pat); end
        drain("rr", 20);
        tests++; if (fc !== 32'd4 || gi !== 1'b1) begin fails++; $display("FAIL rr_end: got cnt=%0d gi=%0d required 4/1", fc, gi); end
    endtask

    task automatic test_frame_lock;
        int b0 = beats, n = 0;
        add_frame(1, 32'h300, 4, 4);
        while (beats < b0 + 1 && n < 20) begin @(posedge udp_clk); #2; n++; end
        add_frame(0, 32'h400, 2, 2);
        n = 0;
        do begin
            @(negedge udp_clk);
            n++;
            if (gv && gi == 1'b1) begin
                tests++;
                if (s_if.tready[0] !== 1'b0) begin fails++; $display("FAIL lock_ready0: got %0b required 0", s_if.tready[0]); end
            end
        end while (!(gv && gi == 1'b0) && n < 20);
        tests++; if (!(gv && gi == 1'b0)) begin fails++; $display("FAIL lock_next_grant: got gv=%0b gi=%0d required 1/0", gv, gi); end
        drain("lock", 20);
    endtask

    task automatic test_backpressure;
        logic [3:0] pat = 4'b1001;
        int b0 = beats;
        add_frame(0, 32'h500, 4, 4);
        for (int k = 0; k < 40; k++) begin
            @(posedge udp_clk);
            #1 m_if.tready = pat[k%4];
            #1;
            if (exp_q.size() == 0 && src_q[0].size() == 0) break;
            @(negedge udp_clk);
            if (gv) begin
                tests++;
                if (s_if.tready !== {1'b0, m_if.tready[0]}) begin
                    fails++; $display("FAIL bp_ready_mirror: got %b required 0%0b", s_if.tready, m_if.tready);
                end
            end
        end
        m_if.tready = 1'b1;
        drain("bp", 20);
        tests++; if (beats !== b0 + 4) begin fails++; $display("FAIL bp_beats: got %0d required %0d", beats - b0, 4); end
    endtask

    task automatic test_single_beat;
        logic [5:0] pat;
        logic [31:0] fc0 = fc;
        @(negedge udp_clk);
        add_frame(1, 32'h600, 1, 1);
        add_frame(1, 32'h610, 1, 1);
        add_frame(1, 32'h620, 1, 1);
        @(posedge udp_clk);
        for (int k = 0; k < 6; k++) begin
            @(negedge udp_clk);
            pat[k] = gv;
            if (gv) begin
                tests++;
                if (gi !== 1'b1) begin fails++; $display("FAIL sb_grant_idx: got %0d required 1", gi); end
            end
        end
        tests++; if (pat !== 6'b101010) begin fails++; $display("FAIL sb_pattern: got %b required 101010", pat); end
        drain("sb", 20);
        tests++; if (fc !== fc0 + 32'd3) begin fails++; $display("FAIL sb_cnt: got %0d required %0d", fc, fc0 + 32'd3); end
    endtask

    task automatic test_reset_mid_frame;
        int b0 = beats, n = 0;
        add_frame(0, 32'h700, 5, 2);
        while (beats < b0 + 1 && n < 20) begin @(posedge udp_clk); #2; n++; end
        udp_reset = 1'b1;
        src_q[0].delete();
        @(posedge udp_clk);
        #2 udp_reset = 1'b0;
        @(negedge udp_clk);
        tests++; if (m_if.tvalid !== 1'b0 || s_if.tready !== 2'b00 || gv !== 1'b0) begin
            fails++; $display("FAIL mid_rst_outputs: got tvalid=%0b tready=%b gv=%0b required 0/00/0", m_if.tvalid, s_if.tready, gv);
        end
        tests++; if (fc !== 32'd0 || gi !== 1'b1) begin fails++; $display("FAIL mid_rst_state: got cnt=%0d gi=%0d required 0/1", fc, gi); end
        tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL mid_rst_partial: got %0d beats missing, required 0", exp_q.size()); end
        add_frame(0, 32'h710, 2, 2);
        drain("post_rst", 20);
        tests++; if (fc !== 32'd1 || gi !== 1'b0) begin fails++; $display("FAIL post_rst_frame: got cnt=%0d gi=%0d required 1/0", fc, gi); end
    endtask

    task automatic test_cnt_wrap;
        int n = 0, k = 0;
        @(posedge udp_clk);
        #1 w_s.tvalid = 2'b01;
        w_s.tlast = 2'b01;
        while (n < 17 && k < 200) begin
            @(negedge udp_clk);
            if (w_m.tvalid[0] && w_m.tready[0]) n++;
            k++;
        end
        @(posedge udp_clk);
        #1 w_s.tvalid = 2'b00;
        @(posedge udp_clk);
        #2;
        tests++; if (n != 17 || wfc !== 4'd1 || wgv !== 1'b0) begin
            fails++; $display("FAIL cnt_wrap: got frames=%0d cnt=%0d gv=%0b required 17/1/0", n, wfc, wgv);
        end
    endtask

    initial begin
        w_s.tvalid = '0; w_s.tlast = '0; w_s.tdata = '0; w_s.tkeep = '0; w_s.tuser = '0;
        w_m.tready = 1'b1;
        m_if.tready = 1'b1;
        test_reset();
        test_single_frame();
        test_round_robin();
        test_frame_lock();
        test_backpressure();
        test_single_beat();
        test_reset_mid_frame();
        test_cnt_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end
endmodule
